// File: rtl/packet_assembler_if.sv
// AXI-Stream style bundle shared by the body input and the packet output of packet_assembler.
// Ports: tdata/tkeep/tuser/tvalid/tlast flow from master to slave; tready flows back.
// Modports: master drives the beat, slave accepts it.
interface packet_assembler_if #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tvalid;
  logic                     tlast;
  logic                     tready;

  modport master (output tdata, output tkeep, output tuser, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/packet_assembler.sv
// Purpose : prepends a 42-byte Eth/IPv4/UDP header to each body packet on a 256-bit stream.
// Latency : header beat one cycle after first body tvalid in IDLE; body beats pass through combinationally.
// Backpressure: body tready follows out tready in BODY, low elsewhere; outputs hold while stalled.
// Ports   : axis_aclk, axis_resetn (async active-low), header field inputs sampled with the first
//           body beat, packet_body_in_axis (slave), packet_out_axis (master).
// Option  : PACKET_ASSEMBLER_TUSER_LEN_ADJ_EN adds 42 to tuser[15:0] of the header beat.
module packet_assembler #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
) (
  input  logic        axis_aclk,
  input  logic        axis_resetn,
  input  logic [47:0] src_mac_addr_in,
  input  logic [47:0] dest_mac_addr_in,
  input  logic [31:0] src_ip_addr_in,
  input  logic [31:0] dest_ip_addr_in,
  input  logic [15:0] src_port_in,
  input  logic [15:0] dest_port_in,
  packet_assembler_if.slave  packet_body_in_axis,
  packet_assembler_if.master packet_out_axis
);

  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

  state_t                 state;
  logic [47:0]            dmac_q, smac_q;
  logic [31:0]            sip_q, dip_q;
  logic [15:0]            sport_q, dport_q;
  logic [TUSER_WIDTH-1:0] tuser_q;
  logic [79:0]            residue_q;     // 10 bytes carried into the next output beat
  logic [9:0]             flush_keep_q;

  logic [8*42-1:0]        hdr_bytes;
  logic [TUSER_WIDTH-1:0] hdr_tuser;
  logic [5:0]             keep_run;
  logic                   run;
  logic                   short_last;
  logic [TKEEP_WIDTH-1:0] body_last_keep;
  logic [9:0]             flush_keep_d;

  logic [TDATA_WIDTH-1:0] out_dat;
  logic [TKEEP_WIDTH-1:0] out_keep;
  logic [TUSER_WIDTH-1:0] out_user;
  logic                   out_vld, out_last, in_rdy;

  // Header byte k lives at hdr_bytes[8k +: 8]; multi-byte fields go MSB first.
  always_comb begin
    hdr_bytes = '0;
    for (int j = 0; j < 6; j++) begin
      hdr_bytes[8*j +: 8]     = dmac_q[8*(5-j) +: 8];
      hdr_bytes[8*(6+j) +: 8] = smac_q[8*(5-j) +: 8];
    end
    hdr_bytes[8*12 +: 8] = 8'h08;
    hdr_bytes[8*14 +: 8] = 8'h45;
    hdr_bytes[8*22 +: 8] = 8'h40;
    hdr_bytes[8*23 +: 8] = 8'h11;
    for (int j = 0; j < 4; j++) begin
      hdr_bytes[8*(26+j) +: 8] = sip_q[8*(3-j) +: 8];
      hdr_bytes[8*(30+j) +: 8] = dip_q[8*(3-j) +: 8];
    end
    for (int j = 0; j < 2; j++) begin
      hdr_bytes[8*(34+j) +: 8] = sport_q[8*(1-j) +: 8];
      hdr_bytes[8*(36+j) +: 8] = dport_q[8*(1-j) +: 8];
    end
  end

`ifdef PACKET_ASSEMBLER_TUSER_LEN_ADJ_EN
  assign hdr_tuser = {tuser_q[TUSER_WIDTH-1:16], tuser_q[15:0] + 16'd42};
`else
  assign hdr_tuser = tuser_q;
`endif

  // Byte count of a last beat: only the contiguous run of keep bits from lane 0 counts.
  always_comb begin
    keep_run = '0;
    run      = 1'b1;
    for (int i = 0; i < TKEEP_WIDTH; i++) begin
      if (run && packet_body_in_axis.tkeep[i]) keep_run = keep_run + 6'd1;
      else                                     run      = 1'b0;
    end
  end

  assign short_last = keep_run <= 6'd22;

  always_comb begin
    for (int i = 0; i < TKEEP_WIDTH; i++) body_last_keep[i] = 6'(i) < keep_run + 6'd10;
    for (int i = 0; i < 10; i++)          flush_keep_d[i]   = 6'(i) + 6'd22 < keep_run;
  end

  always_comb begin
    out_vld  = 1'b0;
    out_dat  = '0;
    out_keep = '0;
    out_last = 1'b0;
    out_user = '0;
    in_rdy   = 1'b0;
    case (state)
      HDR: begin
        out_vld  = 1'b1;
        out_dat  = hdr_bytes[TDATA_WIDTH-1:0];
        out_keep = '1;
        out_user = hdr_tuser;
      end
      BODY: begin
        out_vld  = packet_body_in_axis.tvalid;
        in_rdy   = packet_out_axis.tready;
        out_dat  = {packet_body_in_axis.tdata[175:0], residue_q};
        out_last = packet_body_in_axis.tlast && short_last;
        out_keep = out_last ? body_last_keep : '1;
      end
      FLUSH: begin
        out_vld  = 1'b1;
        out_dat  = {{(TDATA_WIDTH-80){1'b0}}, residue_q};
        out_keep = {{(TKEEP_WIDTH-10){1'b0}}, flush_keep_q};
        out_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign packet_out_axis.tvalid     = out_vld;
  assign packet_out_axis.tdata      = out_dat;
  assign packet_out_axis.tkeep      = out_keep;
  assign packet_out_axis.tlast      = out_last;
  assign packet_out_axis.tuser      = out_user;
  assign packet_body_in_axis.tready = in_rdy;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state        <= IDLE;
      dmac_q       <= '0;
      smac_q       <= '0;
      sip_q        <= '0;
      dip_q        <= '0;
      sport_q      <= '0;
      dport_q      <= '0;
      tuser_q      <= '0;
      residue_q    <= '0;
      flush_keep_q <= '0;
    end else begin
      case (state)
        IDLE: if (packet_body_in_axis.tvalid) begin
          dmac_q  <= dest_mac_addr_in;
          smac_q  <= src_mac_addr_in;
          sip_q   <= src_ip_addr_in;
          dip_q   <= dest_ip_addr_in;
          sport_q <= src_port_in;
          dport_q <= dest_port_in;
          tuser_q <= packet_body_in_axis.tuser;
          state   <= HDR;
        end
        HDR: if (packet_out_axis.tready) begin
          residue_q <= hdr_bytes[8*42-1:TDATA_WIDTH];
          state     <= BODY;
        end
        BODY: if (packet_body_in_axis.tvalid && packet_out_axis.tready) begin
          residue_q <= packet_body_in_axis.tdata[TDATA_WIDTH-1:176];
          if (packet_body_in_axis.tlast) begin
            if (short_last) begin
              state <= IDLE;
            end else begin
              flush_keep_q <= flush_keep_d;
              state        <= FLUSH;
            end
          end
        end
        FLUSH: if (packet_out_axis.tready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
